// File: rtl/teak_action_launcher.sv
// Initiator side of the kernel action control interface: writes launch arguments over AXI-lite,
// runs the go/done handshake, reads the result word back and reports it to the host.
module teak_action_launcher #(
    parameter int unsigned N_ARGS      = 2,
    parameter logic [31:0] ARG_BASE    = 32'h10,
    parameter logic [31:0] RESULT_ADDR = 32'h08
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  launch_valid,
    output logic                  launch_ready,
    input  logic [32*N_ARGS-1:0]  launch_args,
    output logic                  cmpl_valid,
    input  logic                  cmpl_ready,
    output logic [31:0]           cmpl_result,
    output logic [1:0]            cmpl_status,
    output logic [31:0]           cmpl_cycles,
    output logic                  go_0r,
    input  logic                  go_0a,
    input  logic                  done_0r,
    output logic                  done_0a,
    output logic [31:0]           m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [31:0]           m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned IdxW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;

    typedef enum logic [3:0] {
        StIdle, StWr, StWb, StGo, StRun, StDack, StRd, StRr, StCmpl
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic [IdxW-1:0] idx_nxt;
    logic [31:0]     args_q [N_ARGS];
    logic            aw_done;
    logic            w_done;

    assign idx_nxt     = idx_q + 1'b1;
    assign m_axi_wstrb = 4'hF;
    // A channel counts as finished once its valid is gone or is handshaking this cycle.
    assign aw_done     = !m_axi_awvalid || m_axi_awready;
    assign w_done      = !m_axi_wvalid || m_axi_wready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            launch_ready  <= 1'b1;
            cmpl_valid    <= 1'b0;
            cmpl_result   <= '0;
            cmpl_status   <= '0;
            cmpl_cycles   <= '0;
            go_0r         <= 1'b0;
            done_0a       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (launch_valid) begin
                        for (int i = 0; i < N_ARGS; i++) begin
                            args_q[i] <= launch_args[32*i +: 32];
                        end
                        cmpl_status   <= '0;
                        cmpl_cycles   <= '0;
                        idx_q         <= '0;
                        m_axi_awaddr  <= ARG_BASE;
                        m_axi_wdata   <= launch_args[31:0];
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        launch_ready  <= 1'b0;
                        state_q       <= StWr;
                    end
                end
                StWr: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready) m_axi_wvalid <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b0;
                        m_axi_bready  <= 1'b1;
                        state_q       <= StWb;
                    end
                end
                StWb: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) cmpl_status[0] <= 1'b1;
                        if (idx_q == IdxW'(N_ARGS - 1)) begin
                            go_0r   <= 1'b1;
                            state_q <= StGo;
                        end else begin
                            idx_q         <= idx_nxt;
                            m_axi_awaddr  <= ARG_BASE + 32'({idx_nxt, 2'b00});
                            m_axi_wdata   <= args_q[idx_nxt];
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state_q       <= StWr;
                        end
                    end
                end
                StGo: begin
                    // The acknowledge edge itself counts as the first run cycle.
                    if (go_0a) begin
                        go_0r       <= 1'b0;
                        cmpl_cycles <= 32'd1;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (done_0r) begin
                        done_0a <= 1'b1;
                        state_q <= StDack;
                    end else if (cmpl_cycles != 32'hFFFF_FFFF) begin
                        cmpl_cycles <= cmpl_cycles + 32'd1;
                    end
                end
                StDack: begin
                    done_0a <= 1'b0;
                    if (!done_0r) begin
                        m_axi_araddr  <= RESULT_ADDR;
                        m_axi_arvalid <= 1'b1;
                        state_q       <= StRd;
                    end
                end
                StRd: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state_q       <= StRr;
                    end
                end
                StRr: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        cmpl_result  <= m_axi_rdata;
                        if (m_axi_rresp != 2'b00) cmpl_status[1] <= 1'b1;
                        cmpl_valid   <= 1'b1;
                        state_q      <= StCmpl;
                    end
                end
                StCmpl: begin
                    if (cmpl_ready) begin
                        cmpl_valid   <= 1'b0;
                        launch_ready <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_teak_action_launcher.sv
// Randomised bench for teak_action_launcher: AXI-lite slave and action emulators with random
// stalls, plus a transaction-level model of the expected launch sequence checked every cycle.
module tb_teak_action_launcher;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        launch_valid, launch_ready;
    logic [63:0] launch_args;
    logic        cmpl_valid, cmpl_ready;
    logic [31:0] cmpl_result, cmpl_cycles;
    logic [1:0]  cmpl_status;
    logic        go_0r, go_0a, done_0r, done_0a;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    teak_action_launcher #(.N_ARGS(N), .ARG_BASE(32'h10), .RESULT_ADDR(32'h08)) dut (
        .clk(clk), .reset(reset),
        .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_args(launch_args),
        .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_result(cmpl_result),
        .cmpl_status(cmpl_status), .cmpl_cycles(cmpl_cycles),
        .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Knobs written by the stimulus process, read by the emulators.
    int done_delay   = 3;
    int aw_hold      = 0;
    bit aw_stall     = 1'b0;
    bit berr_next    = 1'b0;
    bit rerr_next    = 1'b0;
    bit rnd_err      = 1'b0;

    // AXI slave and action emulator: decide on the handshakes seen at the negedge, drive after.
    bit rst_s, aw_hs, w_hs, b_hs, ar_hs, r_hs, go_hs, dack_hs, go_s;
    bit aw_got, w_got, b_pend, r_pend;
    int b_wait, r_wait, act_phase, act_cnt, drop_wait;

    initial begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        m_axi_bresp = 2'b00;
        m_axi_rresp = 2'b00;
        m_axi_rdata = '0;
        go_0a = 1'b0;
        done_0r = 1'b0;
        forever begin
            @(negedge clk);
            rst_s   = !reset;
            aw_hs   = m_axi_awvalid && m_axi_awready;
            w_hs    = m_axi_wvalid && m_axi_wready;
            b_hs    = m_axi_bvalid && m_axi_bready;
            ar_hs   = m_axi_arvalid && m_axi_arready;
            r_hs    = m_axi_rvalid && m_axi_rready;
            go_hs   = go_0r && go_0a;
            go_s    = go_0r;
            dack_hs = done_0r && done_0a;
            if (aw_stall && m_axi_awvalid && aw_hold > 0) aw_hold--;
            @(posedge clk);
            #1;
            if (rst_s) begin
                {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
                go_0a = 1'b0;
                done_0r = 1'b0;
                {aw_got, w_got, b_pend, r_pend} = '0;
                act_phase = 0;
            end else begin
                if (aw_hs) begin
                    aw_got = 1'b1;
                    aw_stall = 1'b0;
                end
                if (w_hs) w_got = 1'b1;
                if (aw_got && w_got) begin
                    {aw_got, w_got} = '0;
                    b_pend = 1'b1;
                    b_wait = $urandom_range(0, 3);
                end
                if (b_hs) m_axi_bvalid = 1'b0;
                if (b_pend && !m_axi_bvalid) begin
                    if (b_wait == 0) begin
                        m_axi_bvalid = 1'b1;
                        b_pend = 1'b0;
                        m_axi_bresp = (berr_next || (rnd_err && $urandom_range(0, 7) == 0))
                                      ? 2'b10 : 2'b00;
                        berr_next = 1'b0;
                    end else b_wait--;
                end
                if (aw_stall) begin
                    m_axi_awready = (aw_hold == 0);
                    m_axi_wready = 1'b1;
                end else begin
                    m_axi_awready = ($urandom_range(0, 3) != 0);
                    m_axi_wready = ($urandom_range(0, 3) != 0);
                end
                m_axi_arready = ($urandom_range(0, 2) != 0);
                if (ar_hs) begin
                    r_pend = 1'b1;
                    r_wait = $urandom_range(0, 3);
                end
                if (r_hs) m_axi_rvalid = 1'b0;
                if (r_pend && !m_axi_rvalid) begin
                    if (r_wait == 0) begin
                        m_axi_rvalid = 1'b1;
                        r_pend = 1'b0;
                        m_axi_rdata = $urandom;
                        m_axi_rresp = (rerr_next || (rnd_err && $urandom_range(0, 7) == 0))
                                      ? 2'b10 : 2'b00;
                        rerr_next = 1'b0;
                    end else r_wait--;
                end
                if (go_hs) begin
                    go_0a = 1'b0;
                    act_phase = 1;
                    act_cnt = 0;
                end else if (go_s && !go_0a && $urandom_range(0, 2) == 0) begin
                    go_0a = 1'b1;
                end
                if (act_phase == 1) begin
                    act_cnt++;
                    if (act_cnt >= done_delay) begin
                        done_0r = 1'b1;
                        act_phase = 2;
                    end
                end
                if (act_phase == 2 && dack_hs) begin
                    act_phase = 3;
                    drop_wait = $urandom_range(0, 2);
                end
                if (act_phase == 3) begin
                    if (drop_wait == 0) begin
                        done_0r = 1'b0;
                        act_phase = 0;
                    end else drop_wait--;
                end
            end
        end
    end

    // Transaction-level reference: what a launch must look like on each interface.
    int          cyc = 0;
    bit          busy, chk_rst, go_done, done_seen, r_done, first_wr;
    logic [63:0] exp_wr [$];
    logic [63:0] wr_log [$];
    logic [31:0] aw_q [$];
    logic [31:0] w_q [$];
    int          outst, bcnt, dack_cnt, ar_cnt, g_cyc, aw_hi, w_hi, first_aw_hi, first_w_hi;
    int          cmpl_cnt = 0;
    int          launch_cnt = 0;
    logic [31:0] exp_cycles, exp_result;
    logic [1:0]  exp_status;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_dack;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    initial begin
        logic [63:0] pair;
        logic [31:0] a;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_rst) begin
                check("reset_valids", {go_0r, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                      m_axi_arvalid, m_axi_rready, done_0a, cmpl_valid}, 8'h00);
                check("reset_launch_ready", launch_ready, 1'b1);
                check("reset_cmpl_data", {cmpl_result, cmpl_status, cmpl_cycles}, 66'h0);
                chk_rst = 1'b0;
            end
            if (!reset) begin
                chk_rst = 1'b1;
                {busy, go_done, done_seen, r_done, first_wr} = '0;
                exp_wr.delete();
                aw_q.delete();
                w_q.delete();
                {outst, bcnt, dack_cnt, ar_cnt} = '0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_dack} = '0;
            end else begin
                check("launch_ready", launch_ready, !busy);
                if (m_axi_wvalid) check("wstrb", m_axi_wstrb, 4'hF);
                if (p_awv && !p_awr) begin
                    check("awvalid_held", m_axi_awvalid, 1'b1);
                    check("awaddr_stable", m_axi_awaddr, p_awaddr);
                end
                if (p_wv && !p_wr) begin
                    check("wvalid_held", m_axi_wvalid, 1'b1);
                    check("wdata_stable", m_axi_wdata, p_wdata);
                end
                if (p_arv && !p_arr) begin
                    check("arvalid_held", m_axi_arvalid, 1'b1);
                    check("araddr_stable", m_axi_araddr, p_araddr);
                end
                if (first_wr && m_axi_awvalid) aw_hi++;
                if (first_wr && m_axi_wvalid) w_hi++;
                if (m_axi_awvalid && m_axi_awready) begin
                    check("single_outstanding", outst, 0);
                    aw_q.push_back(m_axi_awaddr);
                end
                if (m_axi_wvalid && m_axi_wready) w_q.push_back(m_axi_wdata);
                if (aw_q.size() != 0 && w_q.size() != 0) begin
                    a = aw_q.pop_front();
                    d = w_q.pop_front();
                    outst++;
                    wr_log.push_back({a, d});
                    check("write_expected", exp_wr.size() != 0, 1'b1);
                    if (exp_wr.size() != 0) begin
                        pair = exp_wr.pop_front();
                        check("write_addr_data", {a, d}, pair);
                    end
                    if (first_wr) begin
                        first_wr = 1'b0;
                        first_aw_hi = aw_hi;
                        first_w_hi = w_hi;
                    end
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    check("b_after_write", outst, 1);
                    outst = 0;
                    bcnt++;
                    if (m_axi_bresp != 2'b00) exp_status[0] = 1'b1;
                end
                if (go_0r) check("go_0r_window", {go_done, (exp_wr.size() == 0 && bcnt == N)},
                                 2'b01);
                if (go_0r && go_0a) begin
                    go_done = 1'b1;
                    g_cyc = cyc;
                end
                if (go_done && !done_seen && done_0r && cyc > g_cyc) begin
                    done_seen = 1'b1;
                    exp_cycles = 32'(cyc - g_cyc);
                end
                if (done_0a) begin
                    check("done_0a_after_done", done_seen, 1'b1);
                    check("done_0a_pulse", p_dack, 1'b0);
                    dack_cnt++;
                end
                if (m_axi_arvalid) check("ar_after_dack", {dack_cnt == 1, done_0r}, 2'b10);
                if (m_axi_arvalid && m_axi_arready) begin
                    check("araddr", m_axi_araddr, 32'h08);
                    ar_cnt++;
                end
                if (m_axi_rvalid && m_axi_rready) begin
                    r_done = 1'b1;
                    exp_result = m_axi_rdata;
                    if (m_axi_rresp != 2'b00) exp_status[1] = 1'b1;
                end
                if (cmpl_valid) begin
                    check("cmpl_after_read", r_done, 1'b1);
                    check("cmpl_result", cmpl_result, exp_result);
                    check("cmpl_status", cmpl_status, exp_status);
                    check("cmpl_cycles", cmpl_cycles, exp_cycles);
                end
                if (cmpl_valid && cmpl_ready) begin
                    busy = 1'b0;
                    cmpl_cnt++;
                    check("dack_count", dack_cnt, 1);
                    check("b_count", bcnt, N);
                    check("ar_count", ar_cnt, 1);
                end
                if (launch_valid && launch_ready) begin
                    busy = 1'b1;
                    launch_cnt++;
                    {go_done, done_seen, r_done} = '0;
                    {outst, bcnt, dack_cnt, ar_cnt, aw_hi, w_hi} = '0;
                    exp_status = 2'b00;
                    first_wr = 1'b1;
                    exp_wr.delete();
                    for (int i = 0; i < N; i++) begin
                        exp_wr.push_back({32'h10 + 32'(4 * i), launch_args[32*i +: 32]});
                    end
                end
                p_awv = m_axi_awvalid;
                p_awr = m_axi_awready;
                p_awaddr = m_axi_awaddr;
                p_wv = m_axi_wvalid;
                p_wr = m_axi_wready;
                p_wdata = m_axi_wdata;
                p_arv = m_axi_arvalid;
                p_arr = m_axi_arready;
                p_araddr = m_axi_araddr;
                p_dack = done_0a;
            end
        end
    end

    task automatic start_launch(input logic [63:0] args);
        int t;
        @(posedge clk);
        #1;
        launch_valid = 1'b1;
        launch_args = args;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!launch_ready && t < 200);
        check("launch_accepted", launch_ready, 1'b1);
        @(posedge clk);
        #1;
        launch_valid = 1'b0;
        launch_args = {$urandom, $urandom};
    endtask

    task automatic finish_launch(input int ready_delay, output logic [31:0] cyc_o,
                                 output logic [1:0] st_o);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmpl_valid && t < 3000);
        check("cmpl_arrived", cmpl_valid, 1'b1);
        cyc_o = cmpl_cycles;
        st_o = cmpl_status;
        repeat (ready_delay) @(negedge clk);
        @(posedge clk);
        #1;
        cmpl_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        cmpl_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_go_ready", {go_0r, launch_ready}, 2'b01);
    endtask

    initial begin
        logic [31:0] c;
        logic [1:0]  s;
        int          t;
        int          c0;
        reset = 1'b0;
        launch_valid = 1'b0;
        cmpl_ready = 1'b0;
        launch_args = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", launch_ready, 1'b1);

        // Two argument writes in order, then go/done and the result read.
        wr_log.delete();
        done_delay = 3;
        c0 = cmpl_cnt;
        start_launch({32'h2, 32'h1});
        finish_launch(0, c, s);
        check("t1_write0", wr_log[0], {32'h10, 32'h1});
        check("t1_write1", wr_log[1], {32'h14, 32'h2});
        check("t1_status", s, 2'b00);
        check("t1_cycles", c, 32'd3);
        check("t1_one_cmpl", cmpl_cnt - c0, 1);

        // Address channel stalled while data is accepted at once.
        wr_log.delete();
        aw_hold = 5;
        aw_stall = 1'b1;
        start_launch({$urandom, $urandom});
        finish_launch(1, c, s);
        check("t2_awvalid_cycles", first_aw_hi, 6);
        check("t2_wvalid_cycles", first_w_hi, 1);
        check("t2_write_count", wr_log.size(), N);

        // Run length measured from go acknowledge to done request.
        done_delay = 10;
        start_launch({$urandom, $urandom});
        finish_launch(0, c, s);
        check("t3_cycles", c, 32'd10);

        // Error responses on both channels.
        done_delay = 2;
        berr_next = 1'b1;
        rerr_next = 1'b1;
        start_launch({$urandom, $urandom});
        finish_launch(2, c, s);
        check("t4_status", s, 2'b11);

        // Reset in the middle of a run, then in the middle of a write.
        done_delay = 60;
        start_launch({$urandom, $urandom});
        t = 0;
        while (!go_done && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("t5_reached_run", go_done, 1'b1);
        repeat (3) @(negedge clk);
        pulse_reset();
        aw_hold = 50;
        aw_stall = 1'b1;
        start_launch({$urandom, $urandom});
        repeat (3) @(negedge clk);
        check("t5_in_write", m_axi_awvalid, 1'b1);
        pulse_reset();
        aw_stall = 1'b0;
        aw_hold = 0;
        done_delay = 4;
        start_launch({$urandom, $urandom});
        finish_launch(0, c, s);
        check("t5_fresh_cycles", c, 32'd4);
        check("t5_fresh_status", s, 2'b00);

        // Completion back-pressure with a second launch already waiting.
        done_delay = 5;
        start_launch({$urandom, $urandom});
        t = 0;
        while (!cmpl_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        launch_valid = 1'b1;
        launch_args = {32'hCAFE_0002, 32'hCAFE_0001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_blocked", {cmpl_valid, launch_ready}, 2'b10);
        end
        @(posedge clk);
        #1;
        cmpl_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        cmpl_ready = 1'b0;
        @(negedge clk);
        check("t6_ready_after_cmpl", {cmpl_valid, launch_ready}, 2'b01);
        @(posedge clk);
        #1;
        launch_valid = 1'b0;
        finish_launch(0, c, s);
        check("t6_cycles", c, 32'd5);

        // Random traffic.
        rnd_err = 1'b1;
        for (int k = 0; k < 25; k++) begin
            done_delay = $urandom_range(1, 20);
            start_launch({$urandom, $urandom});
            finish_launch($urandom_range(0, 3), c, s);
        end
        repeat (5) @(negedge clk);
        check("launch_cmpl_balance", cmpl_cnt, launch_cnt - 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
